// File: rtl/rtc_bus_ctrl.sv
// Bus master for a multiplexed address/data RTC port: runs one paced address
// phase and one data phase (read or write) per request; all pad signals are registered.
`timescale 1ns/1ps
module rtc_bus_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 5,
  parameter int T_HOLD  = 2,
  parameter int T_TURN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_req,
  input  logic       i_rd_req,
  input  logic [7:0] i_dir_rtc,
  input  logic [7:0] i_dato,
  output logic [7:0] o_dato_rtc,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe,
  input  logic [7:0] i_ad_in,
  output logic       o_a_d,
  output logic       o_cs_n,
  output logic       o_rd_n,
  output logic       o_wr_n
);

  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_A_SU, S_A_PW, S_A_HD, S_TURN, S_D_SU, S_D_PW, S_D_HD, S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op_wr;
  logic [7:0]         r_addr;
  logic [7:0]         r_data;

  state_t             w_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_advance;
  logic               w_accept;
  logic               w_op_wr;
  logic [7:0]         w_addr;
  logic [7:0]         w_data;

  function automatic int dur(state_t s);
    case (s)
      S_A_SU, S_D_SU: return T_SETUP;
      S_A_PW, S_D_PW: return T_PULSE;
      S_A_HD, S_D_HD: return T_HOLD;
      S_TURN:         return T_TURN;
      default:        return 1;
    endcase
  endfunction

  function automatic state_t follow(state_t s);
    case (s)
      S_IDLE:  return S_A_SU;
      S_A_SU:  return S_A_PW;
      S_A_PW:  return S_A_HD;
      S_A_HD:  return S_TURN;
      S_TURN:  return S_D_SU;
      S_D_SU:  return S_D_PW;
      S_D_PW:  return S_D_HD;
      S_D_HD:  return S_DONE;
      default: return S_IDLE;
    endcase
  endfunction

  // At most three zero-length states in a row (A_HD, TURN, D_SU); pulses are never zero.
  function automatic state_t next_live(state_t s);
    state_t t;
    t = follow(s);
    for (int i = 0; i < 3; i++) begin
      if (dur(t) == 0) t = follow(t);
    end
    return t;
  endfunction

  assign w_accept = (r_state == S_IDLE) && (i_wr_req || i_rd_req);
  // Outputs are computed from the next state, so the accept cycle must see the live inputs.
  assign w_op_wr  = (r_state == S_IDLE) ? i_wr_req  : r_op_wr;
  assign w_addr   = (r_state == S_IDLE) ? i_dir_rtc : r_addr;
  assign w_data   = (r_state == S_IDLE) ? i_dato    : r_data;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_advance  = 1'b0;
    case (r_state)
      S_IDLE:  w_advance = w_accept;
      S_DONE:  w_advance = 1'b1;
      default: begin
        if (r_cnt == '0) w_advance = 1'b1;
        else             w_cnt_next = r_cnt - 1'b1;
      end
    endcase
    if (w_advance) begin
      w_next     = next_live(r_state);
      w_cnt_next = CNT_W'(dur(w_next) - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op_wr    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      o_dato_rtc <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_ad_out   <= '0;
      o_ad_oe    <= 1'b0;
      o_a_d      <= 1'b1;
      o_cs_n     <= 1'b1;
      o_rd_n     <= 1'b1;
      o_wr_n     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_op_wr <= i_wr_req;
        r_addr  <= i_dir_rtc;
        r_data  <= i_dato;
      end
      if (r_state == S_D_PW && r_cnt == '0 && !r_op_wr) o_dato_rtc <= i_ad_in;

      o_busy  <= (w_next != S_IDLE);
      o_done  <= (w_next == S_DONE);
      o_cs_n  <= 1'b1;
      o_rd_n  <= 1'b1;
      o_wr_n  <= 1'b1;
      o_a_d   <= 1'b1;
      o_ad_oe <= 1'b0;
      case (w_next)
        S_A_SU, S_A_PW, S_A_HD: begin
          o_ad_oe  <= 1'b1;
          o_ad_out <= w_addr;
          if (w_next == S_A_PW) begin
            o_cs_n <= 1'b0;
            o_wr_n <= 1'b0;
          end
        end
        S_TURN: o_a_d <= 1'b0;
        S_D_SU, S_D_PW, S_D_HD: begin
          o_a_d   <= 1'b0;
          o_ad_oe <= w_op_wr;
          if (w_op_wr) o_ad_out <= w_data;
          if (w_next == S_D_PW) begin
            o_cs_n <= 1'b0;
            if (w_op_wr) o_wr_n <= 1'b0;
            else         o_rd_n <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Randomized bench for rtc_bus_ctrl: per-cycle pad waveform compared against
// phase windows computed arithmetically from the timing parameters.
`timescale 1ns/1ps
module tb_rtc_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_a = 1'b0, rd_a = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
  logic [7:0] addr = '0, data = '0, rtc_val = '0;

  logic [7:0] dr_a, ado_a, ad_in_a, dr_b, ado_b, ad_in_b;
  logic       busy_a, done_a, oe_a, ad_a, cs_a, rdn_a, wrn_a;
  logic       busy_b, done_b, oe_b, ad_b, cs_b, rdn_b, wrn_b;
  logic [6:0] obs_a, obs_b;

  // RTC model: valid data only while the read strobe is low, inverted garbage otherwise.
  assign ad_in_a = !rdn_a ? rtc_val : ~rtc_val;
  assign ad_in_b = !rdn_b ? rtc_val : ~rtc_val;
  assign obs_a = {busy_a, done_a, cs_a, wrn_a, rdn_a, ad_a, oe_a};
  assign obs_b = {busy_b, done_b, cs_b, wrn_b, rdn_b, ad_b, oe_b};

  rtc_bus_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_wr_req(wr_a), .i_rd_req(rd_a),
    .i_dir_rtc(addr), .i_dato(data), .o_dato_rtc(dr_a), .o_busy(busy_a),
    .o_done(done_a), .o_ad_out(ado_a), .o_ad_oe(oe_a), .i_ad_in(ad_in_a),
    .o_a_d(ad_a), .o_cs_n(cs_a), .o_rd_n(rdn_a), .o_wr_n(wrn_a)
  );

  rtc_bus_ctrl #(.T_SETUP(0), .T_PULSE(1), .T_HOLD(0), .T_TURN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_wr_req(wr_b), .i_rd_req(rd_b),
    .i_dir_rtc(addr), .i_dato(data), .o_dato_rtc(dr_b), .o_busy(busy_b),
    .o_done(done_b), .o_ad_out(ado_b), .o_ad_oe(oe_b), .i_ad_in(ad_in_b),
    .o_a_d(ad_b), .o_cs_n(cs_b), .o_rd_n(rdn_b), .o_wr_n(wrn_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_rd_a = '0, exp_rd_b = '0;

  localparam logic [6:0] IDLE_PADS = 7'b0011110;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {busy,done,cs_n,wr_n,rd_n,a_d,oe} in cycle k after the accept edge.
  function automatic logic [6:0] model(int k, bit wr, int s, int p, int h, int t);
    int  a_end, d0, dn;
    bit  in_addr, in_apw, in_turn, in_data, in_dpw, busy, done;
    a_end   = s + p + h;
    d0      = a_end + t + 1;
    dn      = d0 + s + p + h;
    in_addr = (k >= 1) && (k <= a_end);
    in_apw  = (k >= 1 + s) && (k <= s + p);
    in_turn = (k > a_end) && (k < d0);
    in_data = (k >= d0) && (k < dn);
    in_dpw  = (k >= d0 + s) && (k < d0 + s + p);
    busy    = (k >= 1) && (k <= dn);
    done    = (k == dn);
    return {busy, done, !(in_apw || in_dpw), !(in_apw || (in_dpw && wr)),
            !(in_dpw && !wr), !(in_turn || in_data), in_addr || (in_data && wr)};
  endfunction

  // Issues a request at the current negedge and checks every cycle up to the idle one after done.
  task automatic run_txn(input bit sel, input bit wr, input bit rd, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] v, input int spur_k);
    int s, p, h, t, dn;
    logic [6:0] e, o;
    logic [7:0] old_rd, exp_dr, got_dr, got_ad;
    bit eff_wr;
    if (sel) begin s = 0; p = 1; h = 0; t = 0; end
    else     begin s = 2; p = 5; h = 2; t = 3; end
    dn      = 1 + 2 * (s + p + h) + t;
    eff_wr  = wr;
    old_rd  = sel ? exp_rd_b : exp_rd_a;
    addr    = a;
    data    = d;
    rtc_val = v;
    if (sel) begin wr_b = wr; rd_b = rd; end
    else     begin wr_a = wr; rd_a = rd; end
    @(posedge clk);
    #1;
    if (sel) begin wr_b = 1'b0; rd_b = 1'b0; end
    else     begin wr_a = 1'b0; rd_a = 1'b0; end
    for (int k = 1; k <= dn + 1; k++) begin
      @(negedge clk);
      e      = model(k, eff_wr, s, p, h, t);
      o      = sel ? obs_b : obs_a;
      got_dr = sel ? dr_b : dr_a;
      got_ad = sel ? ado_b : ado_a;
      check($sformatf("pads k=%0d", k), 32'(o), 32'(e));
      if (e[0] && k <= dn)
        check($sformatf("ad_out k=%0d", k), 32'(got_ad), 32'((k <= s + p + h) ? a : d));
      exp_dr = (!eff_wr && k >= dn - h) ? v : old_rd;
      check($sformatf("dato_rtc k=%0d", k), 32'(got_dr), 32'(exp_dr));
      if (k == spur_k) begin
        if (sel) rd_b = 1'b1; else rd_a = 1'b1;
      end
      if (k == spur_k + 1) begin
        if (sel) rd_b = 1'b0; else rd_a = 1'b0;
      end
    end
    if (!eff_wr) begin
      if (sel) exp_rd_b = v; else exp_rd_a = v;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset pads a", 32'(obs_a), 32'(IDLE_PADS));
    check("reset pads b", 32'(obs_b), 32'(IDLE_PADS));
    check("reset ad_out", 32'(ado_a), 32'h0);
    check("reset dato_rtc", 32'(dr_a), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 1'b1, 1'b0, 8'h21, 8'h45, 8'h00, -1);
    run_txn(1'b0, 1'b0, 1'b1, 8'h22, 8'h00, 8'h59, -1);
    run_txn(1'b0, 1'b1, 1'b1, 8'h30, 8'hA5, 8'h3C, -1);
    run_txn(1'b0, 1'b1, 1'b0, 8'h31, 8'h5A, 8'h77, 10);

    for (int n = 0; n < 25; n++) begin
      bit w, r;
      w = 1'($urandom % 2);
      r = w ? 1'($urandom % 2) : 1'b1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(1'b0, w, r, 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom % 2) ? int'($urandom_range(1, 20)) : -1);
    end

    // Reset in the middle of the address strobe.
    addr = 8'h33;
    data = 8'h44;
    wr_a = 1'b1;
    @(posedge clk);
    #1 wr_a = 1'b0;
    repeat (5) @(posedge clk);
    #2 check("pre-reset cs_n", 32'(cs_a), 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid-reset pads", 32'(obs_a), 32'(IDLE_PADS));
    check("mid-reset dato_rtc", 32'(dr_a), 32'h0);
    exp_rd_a = '0;
    exp_rd_b = '0;
    repeat (3) begin
      @(negedge clk);
      check("in-reset done", 32'(done_a), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'h00, -1);

    // Minimal timing instance: A_PW in cycle 1, D_PW in cycle 2, done in cycle 3.
    run_txn(1'b1, 1'b1, 1'b0, 8'h0F, 8'hF0, 8'h00, -1);
    run_txn(1'b1, 1'b0, 1'b1, 8'h05, 8'h00, 8'hC3, 1);
    run_txn(1'b1, 1'b1, 1'b1, 8'h06, 8'h99, 8'h11, 2);
    for (int n = 0; n < 6; n++) begin
      bit w;
      w = 1'($urandom % 2);
      run_txn(1'b1, w, !w, 8'($urandom), 8'($urandom), 8'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
